gmsk_burst_demod: RTL and testbench

//  Receive-side counterpart to the GMSK burst transmit chain. Takes 6-bit offset-binary I/Q ADC samples and

---
 rtl/gmsk_burst_demod.sv | 209 ++++++++++++++++++++
 tb/tb_gmsk_burst_demod.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gmsk_burst_demod.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | gmsk_burst_demod: 1-bit differential-phase GMSK burst receiver with sync-word acquisition. |
// | Optional: define RX_IQ_SWAP_DETECT_EN to lock on the inverted sync word (I/Q swapped).     |
// | Revision: 1.0                                                                              |
// +--------------------------------------------------------------------------------------------+
module gmsk_burst_demod #(
  parameter int                  SPS          = 4,
  parameter int                  SYNC_LEN     = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 16'hB5C3,
  parameter int                  SYNC_MAX_ERR = 1,
  parameter int                  PAYLOAD_BITS = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sample_strobe,
  input  logic [5:0] adc_inphase,
  input  logic [5:0] adc_quadrature,
  input  logic       rx_enable,
  output logic       symbol_out,
  output logic       symbol_valid,
  output logic       sync_found,
  output logic       busy,
  output logic       burst_done,
  output logic       iq_swapped
);

  localparam int HIST_LEN = (SYNC_LEN - 1) * SPS + 1;
  localparam int FILL_W   = $clog2(HIST_LEN + 1);
  localparam int PH_W     = $clog2(SPS + 1);
  localparam int BIT_W    = $clog2(PAYLOAD_BITS + 1);

  typedef enum logic [1:0] {IDLE, HUNT, PAYLOAD, DONE} state_e;

  state_e                    state_q, state_d;
  logic signed [5:0]         i_q, i_d, q_q, q_d, ip_q, ip_d, qp_q, qp_d;
  logic                      have_q, have_d, s1_vld_q, s1_vld_d;
  logic [HIST_LEN-2:0]       hist_q, hist_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic [PH_W-1:0]           phase_q, phase_d;
  logic [BIT_W-1:0]          bitcnt_q, bitcnt_d;
  logic                      sym_q, sym_d, sv_q, sv_d, sf_q, sf_d;
  logic                      busy_q, busy_d, bd_q, bd_d, swap_q, swap_d;

  logic signed [12:0]        w_ie, w_qe, w_ipe, w_qpe, w_cross;
  logic                      w_disc;
  logic [HIST_LEN-1:0]       w_window;
  logic [SYNC_LEN-1:0]       w_taps;
  logic [FILL_W-1:0]         w_fill_new;
  logic                      w_full, w_match, w_match_inv;

  function automatic int popcnt(input logic [SYNC_LEN-1:0] v);
    int cnt;
    cnt = 0;
    for (int k = 0; k < SYNC_LEN; k++) begin
      if (v[k]) cnt++;
    end
    return cnt;
  endfunction

  assign w_ie    = $signed({{7{i_q[5]}}, i_q});
  assign w_qe    = $signed({{7{q_q[5]}}, q_q});
  assign w_ipe   = $signed({{7{ip_q[5]}}, ip_q});
  assign w_qpe   = $signed({{7{qp_q[5]}}, qp_q});
  assign w_cross = w_ie * w_qpe - w_qe * w_ipe;
  assign w_disc  = !w_cross[12] && (w_cross != 13'sd0);

  // The newest decision is not stored yet; the match window is the stored history plus it.
  assign w_window   = {hist_q, w_disc};
  assign w_fill_new = (fill_q == FILL_W'(HIST_LEN)) ? fill_q : fill_q + FILL_W'(1);
  assign w_full     = (w_fill_new == FILL_W'(HIST_LEN));

  always_comb begin
    w_taps = '0;
    for (int k = 0; k < SYNC_LEN; k++) w_taps[k] = w_window[k*SPS];
  end

  assign w_match = w_full && (popcnt(w_taps ^ SYNC_WORD) <= SYNC_MAX_ERR);
`ifdef RX_IQ_SWAP_DETECT_EN
  assign w_match_inv = w_full && (popcnt(w_taps ^ ~SYNC_WORD) <= SYNC_MAX_ERR);
`else
  assign w_match_inv = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    q_d      = q_q;
    ip_d     = ip_q;
    qp_d     = qp_q;
    have_d   = have_q;
    s1_vld_d = 1'b0;
    hist_d   = hist_q;
    fill_d   = fill_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    sym_d    = sym_q;
    sv_d     = 1'b0;
    sf_d     = 1'b0;
    busy_d   = busy_q;
    bd_d     = 1'b0;
    swap_d   = swap_q;

    if (!rx_enable || state_q == IDLE) begin
      state_d  = rx_enable ? HUNT : IDLE;
      i_d      = '0;
      q_d      = '0;
      ip_d     = '0;
      qp_d     = '0;
      have_d   = 1'b0;
      hist_d   = '0;
      fill_d   = '0;
      phase_d  = '0;
      bitcnt_d = '0;
      busy_d   = 1'b0;
      swap_d   = 1'b0;
    end else if (state_q == DONE) begin
      // Strobes landing here are dropped; the next hunt starts from an empty window.
      state_d = HUNT;
      bd_d    = 1'b1;
      have_d  = 1'b0;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      if (sample_strobe) begin
        i_d      = $signed(adc_inphase ^ 6'h20);
        q_d      = $signed(adc_quadrature ^ 6'h20);
        ip_d     = i_q;
        qp_d     = q_q;
        have_d   = 1'b1;
        s1_vld_d = have_q;
      end
      if (s1_vld_q) begin
        hist_d = w_window[HIST_LEN-2:0];
        fill_d = w_fill_new;
        if (state_q == HUNT) begin
          if (w_match || w_match_inv) begin
            state_d  = PAYLOAD;
            sf_d     = 1'b1;
            busy_d   = 1'b1;
            phase_d  = '0;
            bitcnt_d = '0;
            swap_d   = !w_match;
          end
        end else if (phase_q == PH_W'(SPS - 1)) begin
          phase_d  = '0;
          sv_d     = 1'b1;
          sym_d    = w_disc ^ swap_q;
          bitcnt_d = bitcnt_q + BIT_W'(1);
          if (bitcnt_q == BIT_W'(PAYLOAD_BITS - 1)) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      q_q      <= '0;
      ip_q     <= '0;
      qp_q     <= '0;
      have_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      hist_q   <= '0;
      fill_q   <= '0;
      phase_q  <= '0;
      bitcnt_q <= '0;
      sym_q    <= 1'b0;
      sv_q     <= 1'b0;
      sf_q     <= 1'b0;
      busy_q   <= 1'b0;
      bd_q     <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      q_q      <= q_d;
      ip_q     <= ip_d;
      qp_q     <= qp_d;
      have_q   <= have_d;
      s1_vld_q <= s1_vld_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      sym_q    <= sym_d;
      sv_q     <= sv_d;
      sf_q     <= sf_d;
      busy_q   <= busy_d;
      bd_q     <= bd_d;
      swap_q   <= swap_d;
    end
  end

  assign symbol_out   = sym_q;
  assign symbol_valid = sv_q;
  assign sync_found   = sf_q;
  assign busy         = busy_q;
  assign burst_done   = bd_q;
  assign iq_swapped   = swap_q;

endmodule
`default_nettype wire

// File: tb/tb_gmsk_burst_demod.sv
`default_nettype none
// tb_gmsk_burst_demod: directed bursts; stimulus pushes expected payload bits and their arrival
// cycle into a scoreboard queue, and a monitor pops and compares on every symbol_valid.
module tb_gmsk_burst_demod;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       strobe = 1'b0;
  logic       rx_en = 1'b0;
  logic [5:0] adc_i = 6'd32;
  logic [5:0] adc_q = 6'd32;
  logic       sym_out, sym_vld, sync_f, busy, bdone, iqsw;

  gmsk_burst_demod dut (
    .clock(clk), .reset_n(rst_n), .sample_strobe(strobe),
    .adc_inphase(adc_i), .adc_quadrature(adc_q), .rx_enable(rx_en),
    .symbol_out(sym_out), .symbol_valid(sym_vld), .sync_found(sync_f),
    .busy(busy), .burst_done(bdone), .iq_swapped(iqsw)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] SYNC = 16'hB5C3;
  localparam logic [63:0] PAY  = 64'hDEADBEEF01234567;

  // 16-point circle of radius 28 (22.5 degree steps)
  int COS_T [16] = '{28, 26, 20, 11, 0, -11, -20, -26, -28, -26, -20, -11, 0, 11, 20, 26};

  typedef struct {
    logic bit_v;
    int   cyc;
    logic last;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0, fails = 0;
  int   n_sv = 0, n_sync = 0, n_bd = 0, last_sv_cyc = -1, bd_cyc = -1;
  logic exp_swap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sync_f) n_sync++;
      if (bdone) begin
        n_bd++;
        bd_cyc = cyc;
      end
      if (sym_vld) begin
        exp_t e;
        n_sv++;
        last_sv_cyc = cyc;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_symbol_valid: got symbol_valid=1, expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("payload_bit", sym_out, e.bit_v);
          chk("symbol_latency", cyc, e.cyc);
          chk("busy_at_symbol", busy, !e.last);
          chk("iq_swapped_at_symbol", iqsw, exp_swap);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sample(input int si, input int sq, input int gap);
    adc_i  = 6'(si + 32);
    adc_q  = 6'(sq + 32);
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
    adc_i  = 6'd32;
    adc_q  = 6'd32;
    if (gap > 1) tick(gap - 1);
  endtask

  // Symbol 1 steps the phase clockwise so that i*q_prev - q*i_prev > 0 across every sample.
  task automatic send_burst(input logic [15:0] sw, input logic [63:0] pay, input int last_n,
                            input bit lock, input int n_push, input bit swap, input int gap);
    int   k, j, m, si, sq, t;
    logic b;
    exp_t e;
    k = 0;
    for (int n = 0; n <= last_n; n++) begin
      if (n > 0) begin
        j = (n - 1) / 4;
        b = (j < 16) ? sw[15 - j] : pay[63 - (j - 16)];
        k = (k + (b ? 15 : 1)) & 15;
      end
      si = COS_T[k];
      sq = COS_T[(k + 12) & 15];
      if (swap) begin
        t  = si;
        si = sq;
        sq = t;
      end
      if (lock && n >= 65 && ((n - 65) % 4) == 0) begin
        m = (n - 65) / 4;
        if (m < n_push) begin
          e.bit_v = pay[63 - m];
          e.cyc   = cyc + 2;
          e.last  = (m == 63);
          sb.push_back(e);
        end
      end
      send_sample(si, sq, gap);
    end
  endtask

  task automatic restart();
    rx_en = 1'b0;
    tick(3);
    sb.delete();
    n_sv = 0;
    n_sync = 0;
    n_bd = 0;
    last_sv_cyc = -1;
    bd_cyc = -1;
    rx_en = 1'b1;
    tick(2);
  endtask

  task automatic wait_sv(input int target, input string name);
    int t;
    t = 0;
    while (n_sv < target && t < 100) begin
      tick(1);
      t++;
    end
    chk(name, n_sv, target);
  endtask

  task automatic check_burst(input string name);
    tick(10);
    chk({name, "_sync_count"}, n_sync, 1);
    chk({name, "_symbol_count"}, n_sv, 64);
    chk({name, "_queue_left"}, sb.size(), 0);
    chk({name, "_burst_done_count"}, n_bd, 1);
    chk({name, "_burst_done_cycle"}, bd_cyc, last_sv_cyc + 1);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("reset_outputs", {sym_out, sym_vld, sync_f, busy, bdone, iqsw}, 0);
    rst_n = 1'b1;
    tick(2);

    // clean burst, strobe every 3 clocks
    restart();
    exp_swap = 1'b0;
    send_burst(SYNC, PAY, 320, 1'b1, 64, 1'b0, 3);
    check_burst("clean");
    chk("clean_iq_swapped", iqsw, 0);

    // one flipped sync symbol, back-to-back strobes
    restart();
    send_burst(SYNC ^ 16'h0100, PAY, 320, 1'b1, 64, 1'b0, 1);
    check_burst("one_err");

    // two flipped sync symbols
    restart();
    send_burst(SYNC ^ 16'h0810, PAY, 64, 1'b0, 0, 1'b0, 2);
    tick(10);
    chk("two_err_sync_count", n_sync, 0);
    chk("two_err_symbol_count", n_sv, 0);

    // abort after the 10th payload bit
    restart();
    send_burst(SYNC, PAY, 101, 1'b1, 10, 1'b0, 2);
    wait_sv(10, "abort_symbols_before");
    chk("abort_busy_before", busy, 1);
    rx_en = 1'b0;
    tick(1);
    chk("abort_busy_next_clock", busy, 0);
    for (int n = 0; n < 40; n++) send_sample(COS_T[n & 15], COS_T[(n + 12) & 15], 2);
    tick(5);
    chk("abort_symbol_count", n_sv, 10);
    chk("abort_burst_done", n_bd, 0);

    // reset mid-burst after the 20th payload bit
    restart();
    send_burst(SYNC, PAY, 141, 1'b1, 20, 1'b0, 3);
    wait_sv(20, "reset_symbols_before");
    chk("reset_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_burst_outputs", {sym_out, sym_vld, sync_f, busy, bdone, iqsw}, 0);
    sb.delete();
    tick(3);
    rst_n = 1'b1;
    tick(2);
    for (int n = 0; n < 200; n++) send_sample(0, 0, 1);
    tick(5);
    chk("reset_no_resync_symbols", n_sv, 20);
    chk("reset_sync_count", n_sync, 1);

    // null input
    restart();
    for (int n = 0; n < 10000; n++) send_sample(0, 0, 1);
    tick(5);
    chk("null_sync_count", n_sync, 0);
    chk("null_symbol_count", n_sv, 0);

    // I/Q exchanged
    restart();
`ifdef RX_IQ_SWAP_DETECT_EN
    exp_swap = 1'b1;
    send_burst(SYNC, PAY, 320, 1'b1, 64, 1'b1, 3);
    check_burst("swap");
    chk("swap_flag_held", iqsw, 1);
    rx_en = 1'b0;
    tick(2);
    chk("swap_flag_cleared_idle", iqsw, 0);
`else
    send_burst(SYNC, PAY, 320, 1'b0, 0, 1'b1, 3);
    tick(10);
    chk("swap_sync_count", n_sync, 0);
    chk("swap_symbol_count", n_sv, 0);
    chk("swap_flag", iqsw, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
